// File: rtl/uart_obi_slave.sv
// ---------------------------------------------------------------------------
// uart_obi_slave
//   OBI slave UART peripheral: 8N1, LSB first, programmable baud divider,
//   TX FIFO, single-entry RX holding register and a registered level IRQ.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   req_i / gnt_o       OBI request / grant (grant is combinational)
//   rvalid_o, rdata_o   OBI response, exactly one cycle after each grant
//   we_i, be_i, addr_i  write strobe, byte enables, address ([4:2] decoded)
//   wdata_i             write data
//   tx_o                UART transmit line (idle high)
//   rx_i                UART receive line (asynchronous)
//   irq_o               level interrupt
//
// Bus handshake: a transfer happens in every cycle where req_i is high, since
// gnt_o simply mirrors req_i. All side effects (FIFO push, RX pop, W1C) take
// place in that grant cycle. The response (rvalid_o, rdata_o) follows one
// cycle later; rdata_o carries the read value only in a read response and is
// zero in every other cycle.
// ---------------------------------------------------------------------------
module uart_obi_slave #(
    parameter int unsigned TX_FIFO_DEPTH = 4,
    parameter logic [15:0] DEFAULT_DIV   = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);

    localparam int AW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_BAUD   = 3'd2;
    localparam logic [2:0] A_TXDATA = 3'd3;
    localparam logic [2:0] A_RXDATA = 3'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // ---------------- state registers ----------------
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [15:0]     div_q, div_d;
    logic            irq_q, irq_d;

    logic [7:0]      mem_q [TX_FIFO_DEPTH];
    logic [7:0]      mem_d [TX_FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    tx_state_e       tx_state_q, tx_state_d;
    logic [15:0]     tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;

    rx_state_e       rx_state_q, rx_state_d;
    logic [1:0]      rx_sync_q, rx_sync_d;
    logic            rx_prev_q, rx_prev_d;
    logic [15:0]     rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ovr_q, rx_ovr_d;
    logic            rx_ferr_q, rx_ferr_d;

    // ---------------- decode ----------------
    logic [2:0]  reg_sel;
    logic        wr_acc, rd_acc;
    logic        tx_full, tx_empty, tx_idle;
    logic        push, tx_pop;
    logic        rx_rd, rx_good, rx_bad;
    logic        unused_bits;

    assign reg_sel = addr_i[4:2];
    assign wr_acc  = req_i & we_i;
    assign rd_acc  = req_i & ~we_i;
    assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

    assign tx_full  = (cnt_q == CW'(TX_FIFO_DEPTH));
    assign tx_empty = (cnt_q == '0);
    assign tx_idle  = (tx_state_q == TX_IDLE) & tx_empty;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push  = wr_acc & (reg_sel == A_TXDATA) & be_i[0] & (~tx_full | tx_pop);
    assign rx_rd = rd_acc & (reg_sel == A_RXDATA);

    assign gnt_o    = req_i;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = irq_q;
    assign tx_o     = (tx_state_q == TX_START) ? 1'b0 :
                      (tx_state_q == TX_DATA)  ? tx_shift_q[tx_bit_q] : 1'b1;

    // ---------------- bus and registers ----------------
    always_comb begin
        logic [15:0] baud_new;
        rvalid_d = req_i;
        rdata_d  = '0;
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        baud_new = div_q;
        if (rd_acc) begin
            case (reg_sel)
                A_CTRL:   rdata_d = {28'b0, ctrl_q};
                A_STATUS: rdata_d = {26'b0, rx_ferr_q, rx_ovr_q, rx_valid_q,
                                     tx_idle, tx_empty, tx_full};
                A_BAUD:   rdata_d = {16'b0, div_q};
                A_RXDATA: rdata_d = {24'b0, rx_byte_q};
                default:  rdata_d = '0;
            endcase
        end
        if (wr_acc && reg_sel == A_CTRL && be_i[0]) begin
            ctrl_d = wdata_i[3:0];
        end
        if (wr_acc && reg_sel == A_BAUD && (be_i[0] || be_i[1])) begin
            if (be_i[0]) baud_new[7:0]  = wdata_i[7:0];
            if (be_i[1]) baud_new[15:8] = wdata_i[15:8];
            div_d = (baud_new < 16'd4) ? 16'd4 : baud_new;
        end
        irq_d = (rx_valid_q & ctrl_q[2]) | (tx_empty & ctrl_q[3]);
    end

    // ---------------- TX FIFO ----------------
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = wdata_i[7:0];
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, tx_pop};
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, tx_pop};
    end

    // ---------------- TX FSM ----------------
    // Each bit period uses the divider captured at its start, so a BAUD write
    // only affects the line from the next bit boundary onward.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tx_state_q == TX_IDLE) begin
            if (ctrl_q[0] && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = mem_q[rd_ptr_q];
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                tx_div_d   = div_q;
            end
        end else if (tx_cnt_q == tx_div_q - 16'd1) begin
            tx_cnt_d = '0;
            tx_div_d = div_q;
            if (tx_state_q == TX_START) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = 3'd0;
            end else if (tx_state_q == TX_DATA) begin
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else begin
                // End of stop bit: chain straight into the next frame if possible.
                if (ctrl_q[0] && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = mem_q[rd_ptr_q];
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
    end

    // ---------------- RX FSM ----------------
    always_comb begin
        rx_sync_d  = {rx_sync_q[0], rx_i};
        rx_prev_d  = rx_sync_q[1];
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        if (!ctrl_q[1]) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q[1]) begin
                        rx_state_d = RX_START;
                        rx_cnt_d   = '0;
                        rx_div_d   = div_q;
                    end
                end
                RX_START: begin
                    // Mid-start check rejects short low glitches.
                    if (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1) begin
                        rx_cnt_d = '0;
                        rx_div_d = div_q;
                        rx_bit_d = 3'd0;
                        rx_state_d = rx_sync_q[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_cnt_d   = '0;
                        rx_div_d   = div_q;
                        rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_state_d = RX_IDLE;
                        rx_good    = rx_sync_q[1];
                        rx_bad     = ~rx_sync_q[1];
                    end else begin
                        rx_cnt_d = rx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX holding register and flags ----------------
    // A byte landing in the same cycle as an RXDATA read replaces the one being
    // read, so that case is a normal load rather than an overrun.
    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = rx_ferr_q;
        if (rx_rd) rx_valid_d = 1'b0;
        if (wr_acc && reg_sel == A_STATUS && be_i[0]) begin
            if (wdata_i[4]) rx_ovr_d  = 1'b0;
            if (wdata_i[5]) rx_ferr_d = 1'b0;
        end
        if (rx_good) begin
            if (rx_valid_q && !rx_rd) begin
                rx_ovr_d = 1'b1;
            end else begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end
        if (rx_bad) rx_ferr_d = 1'b1;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            div_q      <= DEFAULT_DIV;
            irq_q      <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DEFAULT_DIV;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_state_q <= RX_IDLE;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_div_q   <= DEFAULT_DIV;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            irq_q      <= irq_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

endmodule
